// File: rtl/flash_read_responder.sv
// Flash-side read responder for the audio address counter.
// A read request level arrives from the slow audio-clock domain. It is synchronized
// into the 50 MHz domain and turned into one single-word Avalon-MM read. The returned
// word is presented with a level-held valid that is released by a 4-phase handshake.
module flash_read_responder #(
    parameter int unsigned ADDR_WIDTH     = 23,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SYNC_STAGES    = 2,   // must be >= 2
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  addr_req,
    input  logic [ADDR_WIDTH-1:0] req_address,
    output logic [DATA_WIDTH-1:0] flash_data,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  read_error,
    output logic                  flash_mem_read,
    output logic [ADDR_WIDTH-1:0] flash_mem_address,
    output logic [3:0]            flash_mem_byteenable,
    output logic [5:0]            flash_mem_burstcount,
    input  logic                  flash_mem_waitrequest,
    input  logic [DATA_WIDTH-1:0] flash_mem_readdata,
    input  logic                  flash_mem_readdatavalid
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitData,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  req_sync_q;
    logic                    req_s;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;

    assign req_s = req_sync_q[SYNC_STAGES-1];

    // Request synchronizer: the address is not synchronized, it is stable while the
    // request level is high and is only sampled once req_s has settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], addr_req};
        end
    end

    // State, address, data, error and timeout registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A new request is only accepted from IDLE, and IDLE is only
    // re-entered once req_s has dropped, so each request yields exactly one read.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_s) begin
                    addr_d  = req_address;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!flash_mem_waitrequest) begin
                    // Data may come back in the very cycle the command is accepted.
                    if (flash_mem_readdatavalid) begin
                        data_d  = flash_mem_readdata;
                        err_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                cnt_d = cnt_q + CntWidth'(1);
                // Valid data wins over a timeout in the same cycle.
                if (flash_mem_readdatavalid) begin
                    data_d  = flash_mem_readdata;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!req_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        flash_mem_read       = (state_q == StIssue);
        busy                 = (state_q != StIdle);
        data_valid           = (state_q == StDone);
        flash_mem_address    = addr_q;
        flash_data           = data_q;
        read_error           = err_q;
        flash_mem_byteenable = 4'hF;
        flash_mem_burstcount = 6'd1;
    end

endmodule

// File: tb/tb_flash_read_responder.sv
// Bench for flash_read_responder: directed requests against a small Avalon slave model,
// with expected addresses and data queued when each request is driven.
module tb_flash_read_responder;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          reset_n;
    logic          addr_req;
    logic [AW-1:0] req_address;
    logic [DW-1:0] flash_data;
    logic          data_valid;
    logic          busy;
    logic          read_error;
    logic          flash_mem_read;
    logic [AW-1:0] flash_mem_address;
    logic [3:0]    flash_mem_byteenable;
    logic [5:0]    flash_mem_burstcount;
    logic          flash_mem_waitrequest;
    logic [DW-1:0] flash_mem_readdata;
    logic          flash_mem_readdatavalid;

    flash_read_responder #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .addr_req               (addr_req),
        .req_address            (req_address),
        .flash_data             (flash_data),
        .data_valid             (data_valid),
        .busy                   (busy),
        .read_error             (read_error),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_burstcount   (flash_mem_burstcount),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboards
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];

    // Slave configuration and bookkeeping
    int            ws_cfg    = 0;
    int            lat_cfg   = 1;
    bit            drop_cfg  = 0;
    logic [DW-1:0] mem_data  = '0;
    bit            inject    = 0;
    int            rd_cycles = 0;
    int            accepted  = 0;
    logic [DW-1:0] last_good = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Avalon slave model: inputs are updated 1 time unit after each rising edge.
    initial begin : slave
        int            ws_left;
        int            countdown;
        bit            in_cmd;
        logic [AW-1:0] first_addr;
        logic [AW-1:0] ea;
        ws_left = 0;
        countdown = 0;
        in_cmd = 0;
        first_addr = '0;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata = $urandom;
            if (!reset_n) begin
                in_cmd = 0;
                countdown = 0;
                flash_mem_waitrequest = 1'b0;
            end else begin
                if (inject) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata = 32'hBAD0BAD0;
                    inject = 0;
                end
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) begin
                        flash_mem_readdatavalid = 1'b1;
                        flash_mem_readdata = mem_data;
                    end
                end
                if (flash_mem_read) begin
                    if (!in_cmd) begin
                        in_cmd = 1;
                        ws_left = ws_cfg;
                        first_addr = flash_mem_address;
                    end
                    rd_cycles++;
                    if (ws_left > 0) begin
                        flash_mem_waitrequest = 1'b1;
                        ws_left--;
                    end else begin
                        flash_mem_waitrequest = 1'b0;
                        in_cmd = 0;
                        accepted++;
                        chk("addr_stable", 64'(flash_mem_address), 64'(first_addr));
                        if (exp_addr_q.size() == 0) begin
                            chk("unexpected_read", 64'(accepted), 64'd0);
                        end else begin
                            ea = exp_addr_q.pop_front();
                            chk("read_addr", 64'(flash_mem_address), 64'(ea));
                        end
                        if (!drop_cfg) begin
                            if (lat_cfg == 0) begin
                                flash_mem_readdatavalid = 1'b1;
                                flash_mem_readdata = mem_data;
                            end else begin
                                countdown = lat_cfg;
                            end
                        end
                    end
                end else begin
                    flash_mem_waitrequest = 1'b0;
                end
            end
        end
    end

    // One full 4-phase transaction.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int ws, input int lat, input bit drop, input string tag);
        int            n;
        int            rd_base;
        int            acc_base;
        int            exp_lat;
        logic [DW-1:0] ed;
        ws_cfg   = ws;
        lat_cfg  = lat;
        drop_cfg = drop;
        mem_data = data;
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(drop ? last_good : data);
        exp_lat  = 1 + ws + (drop ? TO : lat);
        rd_base  = rd_cycles;
        acc_base = accepted;
        req_address = addr;
        @(posedge clk);
        #3 addr_req = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0;
        while (!data_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        ed = exp_data_q.pop_front();
        chk({tag, "_data"}, 64'(flash_data), 64'(ed));
        chk({tag, "_err"}, 64'(read_error), 64'(drop));
        chk({tag, "_rd_cycles"}, 64'(rd_cycles - rd_base), 64'(ws + 1));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid_held"}, 64'(data_valid), 64'd1);
        chk({tag, "_one_read"}, 64'(accepted - acc_base), 64'd1);
        addr_req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid_until_sync"}, 64'(data_valid), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 64'(data_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        if (!drop) last_good = data;
    endtask

    initial begin : main
        int acc_base;
        int n;
        reset_n = 1'b0;
        addr_req = 1'b0;
        req_address = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 64'(flash_data), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(read_error), 64'd0);
        chk("rst_read", 64'(flash_mem_read), 64'd0);
        chk("rst_addr", 64'(flash_mem_address), 64'd0);
        chk("byteenable", 64'(flash_mem_byteenable), 64'hF);
        chk("burstcount", 64'(flash_mem_burstcount), 64'd1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        do_read(23'h00010, 32'hA1B2C3D4, 0, 1, 0, "basic");
        do_read(23'h00123, 32'h5EED5EED, 5, 1, 0, "wait5");
        do_read(23'h00456, 32'h0A0B0C0D, 0, 0, 0, "same_cycle");
        do_read(23'h00789, 32'hFACEFACE, 0, 1, 1, "timeout");
        do_read(23'h0078A, 32'h00BC00BC, 1, 2, 0, "after_timeout");
        do_read(23'h07FFFF, 32'hFFFF0000, 0, 1, 0, "addr_7ffff");
        do_read(23'h000000, 32'h12345678, 0, 3, 0, "addr_zero");
        do_read(23'h7FFFFF, 32'hCAFEBABE, 2, 1, 0, "addr_max");

        // Reset while waiting for read data.
        ws_cfg = 0;
        drop_cfg = 1;
        exp_addr_q.push_back(23'h01234);
        req_address = 23'h01234;
        @(posedge clk);
        #3 addr_req = 1'b1;
        n = 0;
        while (!(busy && !flash_mem_read) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_wait_state", 64'(busy && !flash_mem_read), 64'd1);
        #4 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", 64'(flash_data), 64'd0);
        chk("mid_rst_valid", 64'(data_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(read_error), 64'd0);
        chk("mid_rst_read", 64'(flash_mem_read), 64'd0);
        chk("mid_rst_addr", 64'(flash_mem_address), 64'd0);
        addr_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        inject = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("late_rdv_data", 64'(flash_data), 64'd0);
        chk("late_rdv_valid", 64'(data_valid), 64'd0);
        chk("late_rdv_busy", 64'(busy), 64'd0);
        last_good = '0;

        // Back-to-back requests paced like a slow audio clock.
        acc_base = accepted;
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(i), 32'hC0DE0000 + DW'(i), i % 2, 1 + i, 0, "b2b");
            repeat (15) @(posedge clk);
        end
        chk("b2b_reads", 64'(accepted - acc_base), 64'd4);
        chk("b2b_queue_empty", 64'(exp_addr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
